// File: rtl/float_normalizer.sv
// float_normalizer
//   Normalizes the raw result of a floating-point adder into packed
//   {sign, exponent, mantissa} form. Each NORM cycle evaluates one step:
//   a single right shift for an adder carry, or a single left shift
//   toward the hidden bit. Truncation only, no denormals.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (ready only while IDLE)
//   in_sign               raw sign
//   in_exponent           biased exponent, MSB = adder overflow bit
//   in_mantissa           raw mantissa, [M+1]=carry, [M]=hidden bit
//   in_inexact            bits already lost upstream
//   out_valid / out_ready output handshake (valid only while DONE)
//   out                   packed float
//   overflow, underflow, inexact, zero   result flags
module float_normalizer #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sign,
  input  logic [EXPONENT_SIZE:0]   in_exponent,
  input  logic [MANTISSA_SIZE+1:0] in_mantissa,
  input  logic                     in_inexact,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FLOAT_SIZE-1:0]    out,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     inexact,
  output logic                     zero
);

  localparam int E = EXPONENT_SIZE;
  localparam int M = MANTISSA_SIZE;
  localparam logic [E:0] EXP_ONES = {1'b0, {E{1'b1}}};
  localparam logic [E:0] EXP_ONE  = {{E{1'b0}}, 1'b1};

  // Parameter consistency is checked at elaboration.
  if (FLOAT_SIZE != 1 + EXPONENT_SIZE + MANTISSA_SIZE) begin : g_bad_width
    $error("float_normalizer: FLOAT_SIZE must equal 1+EXPONENT_SIZE+MANTISSA_SIZE");
  end
  if (BIAS <= 0 || BIAS >= (1 << EXPONENT_SIZE) - 1) begin : g_bad_bias
    $error("float_normalizer: BIAS outside exponent range");
  end

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [E:0]      exp_q, exp_d;
  logic [M+1:0]    mant_q, mant_d;
  logic            inx_q, inx_d;
  logic [FLOAT_SIZE-1:0] out_q, out_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            zero_q, zero_d;
  logic            inxo_q, inxo_d;

  // Candidate finalize values: the carry correction is folded in here so
  // a carry result finalizes in the same cycle as its right shift.
  logic [E:0]      fin_exp;
  logic [M+1:0]    fin_mant;
  logic            fin_inx;

  always_comb begin
    fin_exp  = exp_q;
    fin_mant = mant_q;
    fin_inx  = inx_q;
    if (mant_q[M+1]) begin
      // exp_q MSB is clear whenever this path is taken, so +1 cannot wrap.
      fin_exp  = exp_q + EXP_ONE;
      fin_mant = mant_q >> 1;
      fin_inx  = inx_q | mant_q[0];
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    inx_d   = inx_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    inxo_d  = inxo_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exponent;
          mant_d  = in_mantissa;
          inx_d   = in_inexact;
          state_d = NORM;
        end
      end
      NORM: begin
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        zero_d = 1'b0;
        inxo_d = inx_q;
        if (mant_q == '0) begin
          out_d   = '0;
          zero_d  = 1'b1;
          inxo_d  = 1'b0;
          state_d = DONE;
        end else if (exp_q[E]) begin
          out_d   = {sign_q, {E{1'b1}}, {M{1'b0}}};
          ovf_d   = 1'b1;
          state_d = DONE;
        end else if (mant_q[M+1] || mant_q[M]) begin
          inxo_d = fin_inx;
          if (fin_exp >= EXP_ONES) begin
            out_d = {sign_q, {E{1'b1}}, {M{1'b0}}};
            ovf_d = 1'b1;
          end else begin
            out_d = {sign_q, fin_exp[E-1:0], fin_mant[M-1:0]};
          end
          state_d = DONE;
        end else if (exp_q <= EXP_ONE) begin
          // No denormals: anything below the smallest normal flushes to zero.
          out_d   = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
          unf_d   = 1'b1;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          mant_d = {mant_q[M:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
      inxo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
      inxo_q  <= inxo_d;
    end
  end

  // Working registers are always loaded on accept before use.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    exp_q  <= exp_d;
    mant_q <= mant_d;
    inx_q  <= inx_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inxo_q;
  assign zero      = zero_q;

endmodule
